// File: rtl/regfile_sb_pkg.sv
// Shared widths and constants for the regfile_sb integer register file.
package regfile_sb_pkg;
  localparam int XLEN         = 64;
  localparam int NREG         = 32;
  localparam int REG_BUS      = XLEN;
  localparam int REG_ADDR_BUS = 5;
  localparam int SB_W         = 2;

  localparam logic [REG_ADDR_BUS-1:0] REG_ZERO = 5'd0;
  localparam logic [SB_W-1:0]         SB_MAX   = {SB_W{1'b1}};

  typedef logic [REG_BUS-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

  function automatic logic addr_live(input reg_addr_t a);
    return (a != REG_ZERO);
  endfunction
endpackage

// File: rtl/regfile_sb_chk.sv
// Simulation checker for regfile_sb: flags an issue attempted into a saturated counter.
module regfile_sb_chk (
  input logic clk,
  input logic rst,
  input logic sb_set,
  input logic sb_full
);
  sb_set_when_full_a: assert property (@(posedge clk) disable iff (rst) !(sb_set && sb_full))
    else $warning("regfile_sb: sb_set dropped, scoreboard counter saturated");
endmodule

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one saturating counter per architectural register.
module regfile_scoreboard
  import regfile_sb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_set,
  input  logic [REG_ADDR_BUS-1:0] i_set_addr,
  input  logic                    i_clr,
  input  logic [REG_ADDR_BUS-1:0] i_clr_addr,
  output logic                    o_full,
  output logic [NREG-1:0]         o_nz,
  output logic [NREG-1:0]         o_one
);
  logic [NREG-1:0][SB_W-1:0] r_cnt;
  logic [NREG-1:0]           w_inc_v;
  logic [NREG-1:0]           w_dec_v;
  logic                      w_inc;
  logic                      w_dec;

  // Qualify issue and retire, decode them to per-register strobes
  always_comb begin
    o_full = addr_live(i_set_addr) && (r_cnt[i_set_addr] == SB_MAX);
    w_inc  = i_set && addr_live(i_set_addr) && !o_full;
    w_dec  = i_clr && addr_live(i_clr_addr) && (r_cnt[i_clr_addr] != '0);
    for (int i = 0; i < NREG; i++) begin
      w_inc_v[i] = w_inc && (i_set_addr == REG_ADDR_BUS'(i));
      w_dec_v[i] = w_dec && (i_clr_addr == REG_ADDR_BUS'(i));
      o_nz[i]    = (r_cnt[i] != '0);
      o_one[i]   = (r_cnt[i] == SB_W'(1));
    end
  end

  // Counter update; an issue and a retire to the same register cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if (w_inc_v[i] && !w_dec_v[i]) begin
          r_cnt[i] <= r_cnt[i] + SB_W'(1);
        end else if (w_dec_v[i] && !w_inc_v[i]) begin
          r_cnt[i] <= r_cnt[i] - SB_W'(1);
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// 32 x 64-bit register file with same-cycle write bypass and a scoreboard-driven decode stall.
// Optional macro REGFILE_DEBUG_PORT_EN adds dbg_regs / dbg_pending state views.
module regfile_sb
  import regfile_sb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_ena,
  input  logic [REG_ADDR_BUS-1:0] w_addr,
  input  logic [REG_BUS-1:0]      w_data,
  input  logic                    r1_ena,
  input  logic [REG_ADDR_BUS-1:0] r1_addr,
  output logic [REG_BUS-1:0]      r1_data,
  input  logic                    r2_ena,
  input  logic [REG_ADDR_BUS-1:0] r2_addr,
  output logic [REG_BUS-1:0]      r2_data,
  input  logic                    sb_set,
  input  logic [REG_ADDR_BUS-1:0] sb_addr,
  output logic                    sb_full,
  output logic                    stall
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  output logic [NREG*XLEN-1:0]    dbg_regs,
  output logic [NREG-1:0]         dbg_pending
`endif
);
  logic [NREG-1:0][REG_BUS-1:0] r_regs;
  logic                         w_full;
  logic [NREG-1:0]              w_nz;
  logic [NREG-1:0]              w_one;
  logic                         w_pend1;
  logic                         w_pend2;

  regfile_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set      (sb_set),
    .i_set_addr (sb_addr),
    .i_clr      (w_ena),
    .i_clr_addr (w_addr),
    .o_full     (w_full),
    .o_nz       (w_nz),
    .o_one      (w_one)
  );

  // Register storage; x0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '0;
    end else if (w_ena && addr_live(w_addr)) begin
      r_regs[w_addr] <= w_data;
    end else begin
      r_regs <= r_regs;
    end
  end

  // Source 1 read with bypass from the writeback port
  always_comb begin
    r1_data = '0;
    if (!rst && r1_ena && addr_live(r1_addr)) begin
      if (w_ena && (w_addr == r1_addr)) r1_data = w_data;
      else                              r1_data = r_regs[r1_addr];
    end else begin
      r1_data = '0;
    end
  end

  // Source 2 read with bypass from the writeback port
  always_comb begin
    r2_data = '0;
    if (!rst && r2_ena && addr_live(r2_addr)) begin
      if (w_ena && (w_addr == r2_addr)) r2_data = w_data;
      else                              r2_data = r_regs[r2_addr];
    end else begin
      r2_data = '0;
    end
  end

  // A last pending writer retiring this cycle is served by the bypass, so it does not stall
  always_comb begin
    w_pend1 = r1_ena && addr_live(r1_addr) && w_nz[r1_addr]
              && !(w_ena && (w_addr == r1_addr) && w_one[r1_addr]);
    w_pend2 = r2_ena && addr_live(r2_addr) && w_nz[r2_addr]
              && !(w_ena && (w_addr == r2_addr) && w_one[r2_addr]);
    stall   = !rst && (w_pend1 || w_pend2);
    sb_full = !rst && w_full;
  end

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_regs    = r_regs;
  assign dbg_pending = w_nz;
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: per-cycle model comparison plus directed literal checks.
module tb_regfile_sb;
  logic        clk;
  logic        rst;
  logic        w_ena;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic        r1_ena;
  logic [4:0]  r1_addr;
  logic [63:0] r1_data;
  logic        r2_ena;
  logic [4:0]  r2_addr;
  logic [63:0] r2_data;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        sb_full;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_reg [32];
  int          m_cnt [32];
  logic        m_inc;
  logic        m_dec;

  regfile_sb dut (
    .clk     (clk),
    .rst     (rst),
    .w_ena   (w_ena),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .r1_ena  (r1_ena),
    .r1_addr (r1_addr),
    .r1_data (r1_data),
    .r2_ena  (r2_ena),
    .r2_addr (r2_addr),
    .r2_data (r2_data),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .sb_full (sb_full),
    .stall   (stall)
  );

  regfile_sb_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .sb_set  (sb_set),
    .sb_full (sb_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts of in-flight writers and architectural values
  assign m_inc = sb_set && (sb_addr != 5'd0) && (m_cnt[sb_addr] < 3);
  assign m_dec = w_ena && (w_addr != 5'd0) && (m_cnt[w_addr] > 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] <= 64'd0;
        m_cnt[i] <= 0;
      end
    end else begin
      if (w_ena && (w_addr != 5'd0)) m_reg[w_addr] <= w_data;
      if (m_inc && !(m_dec && (w_addr == sb_addr))) m_cnt[sb_addr] <= m_cnt[sb_addr] + 1;
      if (m_dec && !(m_inc && (w_addr == sb_addr))) m_cnt[w_addr] <= m_cnt[w_addr] - 1;
    end
  end

  function automatic logic [63:0] exp_rd(input logic ena, input logic [4:0] a);
    if (rst || !ena || (a == 5'd0)) return 64'd0;
    if (w_ena && (w_addr == a)) return w_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_pend(input logic ena, input logic [4:0] a);
    if (rst || !ena || (a == 5'd0)) return 1'b0;
    if (m_cnt[a] == 0) return 1'b0;
    if (w_ena && (w_addr == a) && (m_cnt[a] == 1)) return 1'b0;
    return 1'b1;
  endfunction

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    chk("cyc_r1_data", r1_data, exp_rd(r1_ena, r1_addr));
    chk("cyc_r2_data", r2_data, exp_rd(r2_ena, r2_addr));
    chk("cyc_stall", {63'd0, stall},
        {63'd0, exp_pend(r1_ena, r1_addr) || exp_pend(r2_ena, r2_addr)});
    chk("cyc_sb_full", {63'd0, sb_full},
        {63'd0, !rst && (sb_addr != 5'd0) && (m_cnt[sb_addr] == 3)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; w_ena = 1'b0; w_addr = 5'd0; w_data = 64'd0;
    r1_ena = 1'b0; r1_addr = 5'd0; r2_ena = 1'b0; r2_addr = 5'd0;
    sb_set = 1'b0; sb_addr = 5'd0;
    step(); step();
    rst = 1'b0;

    // Reset in the middle of operation
    w_ena = 1'b1; w_addr = 5'd5; w_data = 64'hDEAD; r1_ena = 1'b1; r1_addr = 5'd5;
    #2 chk("x5_bypass", r1_data, 64'hDEAD);
    step();
    w_ena = 1'b0;
    #2 chk("x5_stored", r1_data, 64'hDEAD);
    rst = 1'b1;
    #1 chk("r1_in_reset", r1_data, 64'd0);
    chk("stall_in_reset", {63'd0, stall}, 64'd0);
    step(); step();
    rst = 1'b0;
    #2 chk("x5_after_reset", r1_data, 64'd0);
    chk("stall_after_reset", {63'd0, stall}, 64'd0);

    // x0 is hardwired to zero
    w_ena = 1'b1; w_addr = 5'd0; w_data = 64'hFFFF_FFFF_FFFF_FFFF; r1_addr = 5'd0;
    #2 chk("x0_no_bypass", r1_data, 64'd0);
    step();
    w_ena = 1'b0;
    #2 chk("x0_read", r1_data, 64'd0);
    sb_set = 1'b1; sb_addr = 5'd0;
    #2 chk("x0_sb_full", {63'd0, sb_full}, 64'd0);
    step();
    sb_set = 1'b0;
    #2 chk("x0_no_stall", {63'd0, stall}, 64'd0);

    // Same-cycle bypass on source 2
    w_ena = 1'b1; w_addr = 5'd7; w_data = 64'h1234; r2_ena = 1'b1; r2_addr = 5'd7;
    #2 chk("x7_bypass", r2_data, 64'h1234);
    step();
    w_ena = 1'b0;
    #2 chk("x7_stored", r2_data, 64'h1234);

    // Load-use stall
    sb_set = 1'b1; sb_addr = 5'd3;
    step();
    sb_set = 1'b0; r1_addr = 5'd3;
    #2 chk("x3_stall_t1", {63'd0, stall}, 64'd1);
    step();
    #2 chk("x3_stall_t2", {63'd0, stall}, 64'd1);
    step();
    w_ena = 1'b1; w_addr = 5'd3; w_data = 64'h42;
    #2 chk("x3_stall_t3", {63'd0, stall}, 64'd0);
    chk("x3_data_t3", r1_data, 64'h42);
    step();
    w_ena = 1'b0;
    #2 chk("x3_data_t4", r1_data, 64'h42);

    // Three writers to x9, fourth issue dropped at saturation
    r1_addr = 5'd9; sb_set = 1'b1; sb_addr = 5'd9;
    step(); step(); step();
    #2 chk("x9_full", {63'd0, sb_full}, 64'd1);
    chk("x9_stall_full", {63'd0, stall}, 64'd1);
    step();
    sb_set = 1'b0;
    w_ena = 1'b1; w_addr = 5'd9; w_data = 64'd1;
    #2 chk("x9_wb1_stall", {63'd0, stall}, 64'd1);
    step();
    w_data = 64'd2;
    #2 chk("x9_wb2_stall", {63'd0, stall}, 64'd1);
    step();
    w_data = 64'd3;
    #2 chk("x9_wb3_stall", {63'd0, stall}, 64'd0);
    chk("x9_wb3_data", r1_data, 64'd3);
    step();
    w_ena = 1'b0;
    #2 chk("x9_done_stall", {63'd0, stall}, 64'd0);

    // Simultaneous issue and retire to x4
    sb_set = 1'b1; sb_addr = 5'd4;
    step();
    w_ena = 1'b1; w_addr = 5'd4; w_data = 64'h44; r2_addr = 5'd4;
    #2 chk("x4_setclr_stall", {63'd0, stall}, 64'd0);
    chk("x4_setclr_data", r2_data, 64'h44);
    step();
    sb_set = 1'b0; w_ena = 1'b0;
    #2 chk("x4_still_pending", {63'd0, stall}, 64'd1);
    w_ena = 1'b1; w_data = 64'h45;
    step();
    w_ena = 1'b0;
    #2 chk("x4_resolved", {63'd0, stall}, 64'd0);
    chk("x4_data", r2_data, 64'h45);

    step(); step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
